// File: rtl/ws2812_chain.sv
// WS2812 daisy-chain driver: local pixel buffer, serial frame streaming and latch timing.
// Optional `WS2812_RGBW_EN adds a white channel (32-bit GRBW pixels for SK6812RGBW strips).
module ws2812_chain #(
    parameter int NUM_LEDS  = 8,
    parameter int ADDR_W    = 3,
    parameter int TICKS_0H  = 15,
    parameter int TICKS_0L  = 40,
    parameter int TICKS_1H  = 40,
    parameter int TICKS_1L  = 15,
    parameter int TICKS_RST = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_red,
    input  logic [7:0]        wr_green,
    input  logic [7:0]        wr_blue,
`ifdef WS2812_RGBW_EN
    input  logic [7:0]        wr_white,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              led
);

`ifdef WS2812_RGBW_EN
    localparam int PIX_W = 32;
`else
    localparam int PIX_W = 24;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TICK_MAX = max2(max2(max2(TICKS_0H, TICKS_0L), max2(TICKS_1H, TICKS_1L)), TICKS_RST);
    localparam int TW       = $clog2(TICK_MAX + 1);

    // Phase limits are stored as "last tick index" so the compare happens on the final cycle.
    localparam logic [TW-1:0]     T0H_LAST = TW'(TICKS_0H - 1);
    localparam logic [TW-1:0]     T0L_LAST = TW'(TICKS_0L - 1);
    localparam logic [TW-1:0]     T1H_LAST = TW'(TICKS_1H - 1);
    localparam logic [TW-1:0]     T1L_LAST = TW'(TICKS_1L - 1);
    localparam logic [TW-1:0]     TRST_END = TW'(TICKS_RST);
    localparam logic [4:0]        BIT_LAST = 5'(PIX_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BIT   = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   idx_r, idx_nxt_s;
    logic [4:0]          bit_cnt_r, bit_nxt_s;
    logic [TW-1:0]       tick_r, tick_nxt_s;
    logic                phase_r, phase_nxt_s;
    logic [PIX_W-1:0]    shift_r, shift_nxt_s;
    logic                led_r, led_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;

    logic [PIX_W-1:0]    buf_r [NUM_LEDS];
    logic [PIX_W-1:0]    wr_pix_s;
    logic [PIX_W-1:0]    rd_pix_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic [TW-1:0]       hi_last_s;
    logic [TW-1:0]       lo_last_s;

`ifdef WS2812_RGBW_EN
    assign wr_pix_s = {wr_green, wr_red, wr_blue, wr_white};
`else
    assign wr_pix_s = {wr_green, wr_red, wr_blue};
`endif

    // Pixel buffer: written in any state, never reset; out-of-range addresses match no entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                buf_r[i] <= wr_pix_s;
            end
        end
    end

    // Buffer read port: LOAD fetches the current index, BIT pre-fetches the next pixel.
    always_comb begin
        rd_addr_s = (state_r == ST_LOAD) ? idx_r : (idx_r + ADDR_W'(1));
        rd_pix_s  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            rd_pix_s = rd_pix_s | ({PIX_W{rd_addr_s == ADDR_W'(i)}} & buf_r[i]);
        end
    end

    assign hi_last_s = shift_r[PIX_W-1] ? T1H_LAST : T0H_LAST;
    assign lo_last_s = shift_r[PIX_W-1] ? T1L_LAST : T0L_LAST;

    // Next-state and output decode for the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        bit_nxt_s   = bit_cnt_r;
        tick_nxt_s  = tick_r;
        phase_nxt_s = phase_r;
        shift_nxt_s = shift_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                    idx_nxt_s   = '0;
                    bit_nxt_s   = 5'd0;
                    tick_nxt_s  = '0;
                    phase_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                shift_nxt_s = rd_pix_s;
                state_nxt_s = ST_BIT;
                bit_nxt_s   = 5'd0;
                tick_nxt_s  = '0;
                phase_nxt_s = 1'b0;
            end
            ST_BIT: begin
                if (!phase_r) begin
                    if (tick_r == hi_last_s) begin
                        phase_nxt_s = 1'b1;
                        tick_nxt_s  = '0;
                    end else begin
                        tick_nxt_s  = tick_r + TW'(1);
                    end
                end else if (tick_r != lo_last_s) begin
                    tick_nxt_s = tick_r + TW'(1);
                end else begin
                    tick_nxt_s  = '0;
                    phase_nxt_s = 1'b0;
                    if (bit_cnt_r != BIT_LAST) begin
                        bit_nxt_s   = bit_cnt_r + 5'd1;
                        shift_nxt_s = {shift_r[PIX_W-2:0], 1'b0};
                    end else if (idx_r != IDX_LAST) begin
                        // Capture the next pixel on the same edge: no inter-pixel gap.
                        idx_nxt_s   = idx_r + ADDR_W'(1);
                        bit_nxt_s   = 5'd0;
                        shift_nxt_s = rd_pix_s;
                    end else begin
                        bit_nxt_s   = 5'd0;
                        state_nxt_s = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (tick_r == TRST_END) begin
                    state_nxt_s = ST_IDLE;
                    tick_nxt_s  = '0;
                    done_nxt_s  = 1'b1;
                end else begin
                    tick_nxt_s  = tick_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = '0;
                bit_nxt_s   = 5'd0;
                tick_nxt_s  = '0;
                phase_nxt_s = 1'b0;
            end
        endcase
        // The pad follows the FSM one cycle later, which preserves every run length exactly.
        led_nxt_s  = (state_r == ST_BIT) && !phase_r;
        busy_nxt_s = (state_nxt_s != ST_IDLE) || done_nxt_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            bit_cnt_r <= 5'd0;
            tick_r    <= '0;
            phase_r   <= 1'b0;
            shift_r   <= '0;
            led_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            bit_cnt_r <= bit_nxt_s;
            tick_r    <= tick_nxt_s;
            phase_r   <= phase_nxt_s;
            shift_r   <= shift_nxt_s;
            led_r     <= led_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign led  = led_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed self-checking bench for ws2812_chain: two pixels, 7-cycle bit periods, 20-cycle latch.
module tb_ws2812_chain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_red = 8'd0;
    logic [7:0] wr_green = 8'd0;
    logic [7:0] wr_blue = 8'd0;
`ifdef WS2812_RGBW_EN
    logic [7:0] wr_white = 8'd0;
`endif
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       led;

    int total = 0;
    int bad = 0;

    logic wave [0:1023];
    logic bsy  [0:1023];
    int   first;
    int   done_at;
    int   last_done;
    int   done_cnt;

    ws2812_chain #(
        .NUM_LEDS(2), .ADDR_W(3),
        .TICKS_0H(2), .TICKS_0L(5), .TICKS_1H(5), .TICKS_1L(2), .TICKS_RST(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
`ifdef WS2812_RGBW_EN
        .wr_white(wr_white),
`endif
        .start(start), .busy(busy), .done(done), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_pix(input logic [2:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_red = r; wr_green = g; wr_blue = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode: 0 plain, 1 mid-frame writes, 2 ignored start/address, 3 start held high
    task automatic run_frame(input int mode, input int want_done, input int tail);
        first = -1; done_at = -1; last_done = -1; done_cnt = 0;
        for (int c = 0; c < 1024; c++) begin
            wave[c] = 1'b0;
            bsy[c]  = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            wave[i] = led;
            bsy[i]  = busy;
            if (first < 0 && led) first = i;
            if (done) begin
                done_cnt++;
                last_done = i;
                if (done_at < 0) done_at = i;
            end
            wr_en = 1'b0;
            if (mode == 3) start = (done_at < 0) || (i == done_at);
            else           start = 1'b0;
            if (mode == 1 && i == 30) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_red = 8'h00; wr_green = 8'h00; wr_blue = 8'h00;
            end
            if (mode == 1 && i == 31) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_red = 8'hFF; wr_green = 8'hFF; wr_blue = 8'hFF;
            end
            if (mode == 2 && (i == 50 || i == 345)) start = 1'b1;
            if (mode == 2 && i == 60) begin
                wr_en = 1'b1; wr_addr = 3'd3; wr_red = 8'h11; wr_green = 8'h22; wr_blue = 8'h33;
            end
            if (done_cnt >= want_done && i >= last_done + tail) break;
        end
        start = 1'b0;
        wr_en = 1'b0;
        check("done_count", done_cnt, want_done);
    endtask

    // Decodes six GRB bytes and compares the whole waveform cycle by cycle up to done.
    task automatic check_frame(input string tag, input logic [47:0] exp_bytes);
        int         mism;
        logic [7:0] got;
        logic       e;
        logic       bv;
        check({tag, "_first_rise"}, first, 32'd2);
        check({tag, "_busy_at_accept"}, bsy[0], 1'b1);
        for (int j = 0; j < 6; j++) begin
            got = 8'd0;
            for (int k = 0; k < 8; k++) got = {got[6:0], wave[2 + 7 * (8 * j + k) + 3]};
            check($sformatf("%s_byte%0d", tag, j), got, exp_bytes[47 - 8 * j -: 8]);
        end
        mism = 0;
        for (int c = 0; c <= done_at && c < 1024; c++) begin
            e = 1'b0;
            if (c >= 2 && c < 338) begin
                bv = exp_bytes[47 - (c - 2) / 7];
                e  = ((c - 2) % 7) < (bv ? 5 : 2);
            end
            if (wave[c] !== e) mism++;
        end
        check({tag, "_wave_mism"}, mism, 32'd0);
        check({tag, "_done_at"}, done_at, 32'd358);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1);
    end

    initial begin
        int dcnt;
        repeat (3) @(negedge clk);
        check("rst_led", led, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;

        write_pix(3'd0, 8'h00, 8'hFF, 8'h00);
        write_pix(3'd1, 8'hAA, 8'h00, 8'h55);
        run_frame(0, 1, 3);
        check_frame("basic", 48'hFF0000_00AA55);
        check("basic_busy_in_done", bsy[done_at], 1'b1);
        check("basic_busy_after", bsy[done_at + 1], 1'b0);

        run_frame(1, 1, 3);
        check_frame("coh", 48'hFF0000_FFFFFF);

        run_frame(2, 1, 40);
        check_frame("ign", 48'h000000_FFFFFF);
        check("ign_idle_after", bsy[done_at + 40], 1'b0);

        // Reset asserted during the high phase of the first bit.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_led_before", led, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_led", led, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("rst_no_done", dcnt, 32'd0);
        check("rst_idle_busy", busy, 1'b0);

        write_pix(3'd0, 8'h34, 8'h12, 8'h56);
        write_pix(3'd1, 8'h00, 8'hC3, 8'h0F);
        run_frame(0, 1, 3);
        check_frame("post", 48'h123456_C3000F);

        run_frame(3, 2, 3);
        check_frame("b2b", 48'h123456_C3000F);
        check("b2b_busy_done", bsy[done_at], 1'b1);
        check("b2b_busy_load", bsy[done_at + 1], 1'b1);
        check("b2b_led_load", wave[done_at + 2], 1'b0);
        check("b2b_led_rise", wave[done_at + 3], 1'b1);
        check("b2b_second_done", last_done, done_at + 359);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
